// File: rtl/pool_game_pkg.sv
// Shared types and helpers for the pool game scoring logic.
package pool_game_pkg;

   typedef enum logic [1:0] {
      PLAY,
      CUE_WAIT,
      RESPAWN,
      OVER
   } score_state_t;

   localparam int NUM_BALLS = 4;
   localparam int BALL_A    = 0;
   localparam int BALL_B    = 1;
   localparam int BALL_C    = 2;
   localparam int BALL_D    = 3;

   // Number of object balls (B, C, D) pocketed in one cycle.
   function automatic logic [1:0] countObjects(input logic b, input logic c, input logic d);
      countObjects = 2'(b) + 2'(c) + 2'(d);
   endfunction

endpackage

// File: rtl/ball_event_edge.sv
// Registered rising-edge detector for one ball's "scored" level.
// The pulse is gated by a qualify input so an already-pocketed ball cannot fire again.
module ball_event_edge (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic level,
   input  logic qualify,
   output logic pulse
);

   logic curLevel;
   logic prevLevel;

   // Sample the level once, then keep one cycle of history for edge detection.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         curLevel  <= 1'b0;
         prevLevel <= 1'b0;
      end else if (clear) begin
         curLevel  <= 1'b0;
         prevLevel <= 1'b0;
      end else begin
         curLevel  <= level;
         prevLevel <= curLevel;
      end
   end

   assign pulse = curLevel & ~prevLevel & qualify;

endmodule

// File: rtl/ball_score_keeper.sv
// Pocket-event scorekeeper: sticky hide flags, saturating score and foul count,
// and the cue-ball foul / respawn sequence.
module ball_score_keeper
   import pool_game_pkg::*;
#(
   parameter int SCORE_W         = 8,
   parameter int POINTS_PER_BALL = 10,
   parameter int FOUL_PENALTY    = 5,
   parameter int RESPAWN_FRAMES  = 60,
   parameter int FRAME_CNT_W     = 7,
   parameter int FOUL_W          = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               startOfFrame,
   input  logic               new_game,
   input  logic               ballA_scored,
   input  logic               ballB_scored,
   input  logic               ballC_scored,
   input  logic               ballD_scored,
   output logic               ballA_hide,
   output logic               ballB_hide,
   output logic               ballC_hide,
   output logic               ballD_hide,
   output logic               cue_respawn,
   output logic               score_event,
   output logic [SCORE_W-1:0] score,
   output logic [FOUL_W-1:0]  foul_count,
   output logic               game_over
);

   localparam int NET_W = SCORE_W + 3;
   localparam logic signed [NET_W-1:0]     MAX_NET    = NET_W'((1 << SCORE_W) - 1);
   localparam logic [FRAME_CNT_W-1:0]      LAST_FRAME = FRAME_CNT_W'(RESPAWN_FRAMES - 1);

   score_state_t              state;
   score_state_t              stateNext;
   logic [NUM_BALLS-1:0]      scoredVec;
   logic [NUM_BALLS-1:0]      hide;
   logic [NUM_BALLS-1:0]      hideNext;
   logic [NUM_BALLS-1:0]      ballEvent;
   logic [NUM_BALLS-1:0]      accObj;
   logic [FRAME_CNT_W-1:0]    frameCnt;
   logic [FRAME_CNT_W-1:0]    frameNext;
   logic [SCORE_W-1:0]        scoreNext;
   logic [FOUL_W-1:0]         foulNext;
   logic                      respawnNext;
   logic                      scoreEvNext;
   logic                      cueEv;
   logic                      allHidden;
   logic [1:0]                nObj;
   logic signed [NET_W-1:0]   baseAmt;
   logic signed [NET_W-1:0]   addAmt;
   logic signed [NET_W-1:0]   subAmt;
   logic signed [NET_W-1:0]   net;

   assign scoredVec = {ballD_scored, ballC_scored, ballB_scored, ballA_scored};

   for (genvar i = 0; i < NUM_BALLS; i++) begin : gEdge
      ball_event_edge uEdge (
         .clk     (clk),
         .rst     (reset),
         .clear   (new_game),
         .level   (scoredVec[i]),
         .qualify (~hide[i]),
         .pulse   (ballEvent[i])
      );
   end

   assign allHidden  = hide[BALL_B] & hide[BALL_C] & hide[BALL_D];
   assign ballA_hide = hide[BALL_A];
   assign ballB_hide = hide[BALL_B];
   assign ballC_hide = hide[BALL_C];
   assign ballD_hide = hide[BALL_D];

   // Next-state, score and flag computation for one cycle of events.
   always_comb begin
      stateNext   = state;
      hideNext    = hide;
      scoreNext   = score;
      foulNext    = foul_count;
      frameNext   = frameCnt;
      respawnNext = 1'b0;
      scoreEvNext = 1'b0;
      accObj      = '0;
      cueEv       = 1'b0;
      nObj        = '0;
      baseAmt     = '0;
      addAmt      = '0;
      subAmt      = '0;
      net         = '0;

      if (state != OVER) begin
         if (allHidden) begin
            // Game end outranks any pending respawn or new events.
            stateNext = OVER;
         end else begin
            if (state == PLAY || state == CUE_WAIT) begin
               accObj = ballEvent & ~NUM_BALLS'(1 << BALL_A);
            end
            cueEv    = ballEvent[BALL_A] && (state == PLAY);
            hideNext = hide | accObj;
            nObj     = countObjects(accObj[BALL_B], accObj[BALL_C], accObj[BALL_D]);

            // Bonus and penalty are merged before clamping so a combined event is one update.
            baseAmt = $signed(NET_W'(score));
            addAmt  = $signed(NET_W'(int'(nObj) * POINTS_PER_BALL));
            subAmt  = cueEv ? $signed(NET_W'(FOUL_PENALTY)) : '0;
            net     = baseAmt + addAmt - subAmt;
            if (net[NET_W-1]) begin
               scoreNext = '0;
            end else if (net > MAX_NET) begin
               scoreNext = '1;
            end else begin
               scoreNext = net[SCORE_W-1:0];
            end
            scoreEvNext = (scoreNext != score);

            if (cueEv) begin
               hideNext[BALL_A] = 1'b1;
               foulNext         = (&foul_count) ? foul_count : foul_count + 1'b1;
               frameNext        = '0;
               stateNext        = CUE_WAIT;
            end

            if (state == CUE_WAIT && startOfFrame) begin
               if (frameCnt == LAST_FRAME) begin
                  stateNext        = RESPAWN;
                  respawnNext      = 1'b1;
                  hideNext[BALL_A] = 1'b0;
               end else begin
                  frameNext = frameCnt + 1'b1;
               end
            end else if (state == RESPAWN) begin
               stateNext = PLAY;
            end
         end
      end
   end

   // State and registered outputs; new_game clears exactly like reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= PLAY;
         hide        <= '0;
         score       <= '0;
         foul_count  <= '0;
         frameCnt    <= '0;
         cue_respawn <= 1'b0;
         score_event <= 1'b0;
         game_over   <= 1'b0;
      end else if (new_game) begin
         state       <= PLAY;
         hide        <= '0;
         score       <= '0;
         foul_count  <= '0;
         frameCnt    <= '0;
         cue_respawn <= 1'b0;
         score_event <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         state       <= stateNext;
         hide        <= hideNext;
         score       <= scoreNext;
         foul_count  <= foulNext;
         frameCnt    <= frameNext;
         cue_respawn <= respawnNext;
         score_event <= scoreEvNext;
         game_over   <= (stateNext == OVER);
      end
   end

endmodule

// File: tb/tb_ball_score_keeper.sv
// Self-checking bench for ball_score_keeper: directed scenarios plus randomized
// traffic compared against a behavioural game model.
module tb_ball_score_keeper;

   localparam int RESPAWN_FRAMES = 60;
   localparam int M_PLAY    = 0;
   localparam int M_CUEWAIT = 1;
   localparam int M_RESPAWN = 2;
   localparam int M_OVER    = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       startOfFrame = 1'b0;
   logic       newGame = 1'b0;
   logic [3:0] lvl = 4'b0000;

   logic       aHide, bHide, cHide, dHide, cueRespawn, scoreEvent, gameOver;
   logic [7:0] score;
   logic [3:0] fouls;
   logic       aHideS, bHideS, cHideS, dHideS, cueRespawnS, scoreEventS, gameOverS;
   logic [3:0] scoreS;
   logic [3:0] foulsS;

   int checks = 0;
   int failures = 0;
   int evCount = 0;
   int respawnCount = 0;

   // Behavioural model state
   int mHide[4];
   int mS1[4];
   int mS2[4];
   int mMode, mLeft, mScore, mScoreSat, mFouls;
   bit mEv, mEvSat, mResp;

   always #5 clk = ~clk;

   ball_score_keeper dut (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .new_game(newGame),
      .ballA_scored(lvl[0]), .ballB_scored(lvl[1]), .ballC_scored(lvl[2]), .ballD_scored(lvl[3]),
      .ballA_hide(aHide), .ballB_hide(bHide), .ballC_hide(cHide), .ballD_hide(dHide),
      .cue_respawn(cueRespawn), .score_event(scoreEvent), .score(score),
      .foul_count(fouls), .game_over(gameOver)
   );

   ball_score_keeper #(.SCORE_W(4)) dutSat (
      .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .new_game(newGame),
      .ballA_scored(lvl[0]), .ballB_scored(lvl[1]), .ballC_scored(lvl[2]), .ballD_scored(lvl[3]),
      .ballA_hide(aHideS), .ballB_hide(bHideS), .ballC_hide(cHideS), .ballD_hide(dHideS),
      .cue_respawn(cueRespawnS), .score_event(scoreEventS), .score(scoreS),
      .foul_count(foulsS), .game_over(gameOverS)
   );

   function automatic int clampTo(int v, int hi);
      if (v < 0) return 0;
      if (v > hi) return hi;
      return v;
   endfunction

   task automatic modelClear();
      for (int b = 0; b < 4; b++) begin
         mHide[b] = 0; mS1[b] = 0; mS2[b] = 0;
      end
      mMode = M_PLAY; mLeft = 0; mScore = 0; mScoreSat = 0; mFouls = 0;
      mEv = 0; mEvSat = 0; mResp = 0;
   endtask

   // One clock edge of the game rules, applied to the inputs seen at that edge.
   task automatic modelStep();
      int ev[4];
      int n;
      int cue;
      int prevMode;
      int raw;
      int nv;
      if (reset || newGame) begin
         modelClear();
         return;
      end
      mEv = 0; mEvSat = 0; mResp = 0;
      for (int b = 0; b < 4; b++) ev[b] = (mS1[b] == 1 && mS2[b] == 0 && mHide[b] == 0) ? 1 : 0;
      if (mMode != M_OVER) begin
         if (mHide[1] != 0 && mHide[2] != 0 && mHide[3] != 0) begin
            mMode = M_OVER;
         end else begin
            prevMode = mMode; n = 0; cue = 0;
            if (prevMode == M_PLAY || prevMode == M_CUEWAIT)
               for (int b = 1; b < 4; b++) if (ev[b] != 0) begin mHide[b] = 1; n++; end
            if (prevMode == M_PLAY && ev[0] != 0) begin
               cue = 1; mHide[0] = 1;
               if (mFouls < 15) mFouls++;
               mLeft = RESPAWN_FRAMES; mMode = M_CUEWAIT;
            end
            raw = mScore + 10 * n - 5 * cue;
            nv = clampTo(raw, 255); mEv = (nv != mScore); mScore = nv;
            raw = mScoreSat + 10 * n - 5 * cue;
            nv = clampTo(raw, 15); mEvSat = (nv != mScoreSat); mScoreSat = nv;
            if (prevMode == M_CUEWAIT && startOfFrame) begin
               mLeft--;
               if (mLeft == 0) begin mMode = M_RESPAWN; mResp = 1; mHide[0] = 0; end
            end else if (prevMode == M_RESPAWN) begin
               mMode = M_PLAY;
            end
         end
      end
      for (int b = 0; b < 4; b++) begin mS2[b] = mS1[b]; mS1[b] = int'(lvl[b]); end
   endtask

   task automatic tick();
      @(posedge clk);
      modelStep();
      @(negedge clk);
      if (scoreEvent === 1'b1) evCount++;
      if (cueRespawn === 1'b1) respawnCount++;
   endtask

   task automatic frame();
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0; tick();
   endtask

   task automatic restart();
      newGame = 1'b1; tick(); newGame = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; lvl = '0;
      tick(); tick();
      checks++; if ({aHide, bHide, cHide, dHide} !== 4'b0000) begin failures++; $display("FAIL reset_hide: got %b expected 0000", {aHide, bHide, cHide, dHide}); end
      checks++; if ({cueRespawn, scoreEvent, gameOver} !== 3'b000) begin failures++; $display("FAIL reset_pulses: got %b expected 000", {cueRespawn, scoreEvent, gameOver}); end
      checks++; if (score !== 8'd0 || fouls !== 4'd0 || scoreS !== 4'd0) begin failures++; $display("FAIL reset_counts: got score=%0d fouls=%0d scoreS=%0d expected 0/0/0", score, fouls, scoreS); end
      reset = 1'b0;
   endtask

   task automatic test_hold_single();
      lvl = '0; restart(); evCount = 0;
      lvl[1] = 1'b1; tick();
      checks++; if (bHide !== 1'b0) begin failures++; $display("FAIL b_hide_early: got %b expected 0", bHide); end
      tick();
      checks++; if (bHide !== 1'b1) begin failures++; $display("FAIL b_hide_set: got %b expected 1", bHide); end
      checks++; if (score !== 8'd10 || scoreEvent !== 1'b1) begin failures++; $display("FAIL b_score: got score=%0d ev=%b expected 10/1", score, scoreEvent); end
      repeat (18) tick();
      checks++; if (score !== 8'd10 || evCount != 1) begin failures++; $display("FAIL b_hold: got score=%0d events=%0d expected 10/1", score, evCount); end
      lvl[1] = 1'b0;
   endtask

   task automatic test_pair_then_over();
      lvl = '0; restart(); evCount = 0;
      lvl[2] = 1'b1; lvl[3] = 1'b1; tick(); tick();
      checks++; if (score !== 8'd20 || {cHide, dHide} !== 2'b11) begin failures++; $display("FAIL cd_score: got score=%0d hide=%b expected 20/11", score, {cHide, dHide}); end
      tick();
      checks++; if (evCount != 1 || gameOver !== 1'b0) begin failures++; $display("FAIL cd_single_event: got events=%0d over=%b expected 1/0", evCount, gameOver); end
      lvl[1] = 1'b1; tick(); tick();
      checks++; if (score !== 8'd30 || bHide !== 1'b1 || gameOver !== 1'b0) begin failures++; $display("FAIL b_last: got score=%0d hide=%b over=%b expected 30/1/0", score, bHide, gameOver); end
      tick();
      checks++; if (gameOver !== 1'b1) begin failures++; $display("FAIL game_over: got %b expected 1", gameOver); end
      lvl = '0;
   endtask

   task automatic test_cue_foul();
      lvl = '0; restart(); evCount = 0; respawnCount = 0;
      lvl[0] = 1'b1; tick(); tick();
      checks++; if (aHide !== 1'b1 || fouls !== 4'd1 || score !== 8'd0 || evCount != 0) begin failures++; $display("FAIL cue_at_zero: got hide=%b fouls=%0d score=%0d events=%0d expected 1/1/0/0", aHide, fouls, score, evCount); end
      lvl[0] = 1'b0;
      repeat (RESPAWN_FRAMES - 1) frame();
      checks++; if (respawnCount != 0 || aHide !== 1'b1) begin failures++; $display("FAIL cue_wait_59: got respawns=%0d hide=%b expected 0/1", respawnCount, aHide); end
      startOfFrame = 1'b1; tick(); startOfFrame = 1'b0;
      checks++; if (cueRespawn !== 1'b1 || aHide !== 1'b0) begin failures++; $display("FAIL respawn_pulse: got respawn=%b hide=%b expected 1/0", cueRespawn, aHide); end
      tick();
      checks++; if (cueRespawn !== 1'b0 || respawnCount != 1) begin failures++; $display("FAIL respawn_once: got respawn=%b count=%0d expected 0/1", cueRespawn, respawnCount); end
      lvl[0] = 1'b1; tick(); tick();
      checks++; if (fouls !== 4'd2 || aHide !== 1'b1) begin failures++; $display("FAIL second_foul: got fouls=%0d hide=%b expected 2/1", fouls, aHide); end
      lvl[0] = 1'b0;
   endtask

   task automatic test_cue_with_object();
      lvl = '0; restart();
      lvl[2] = 1'b1; tick(); tick(); lvl[2] = 1'b0;
      evCount = 0;
      lvl[0] = 1'b1; lvl[1] = 1'b1; tick(); tick();
      checks++; if (score !== 8'd15 || fouls !== 4'd1 || scoreEvent !== 1'b1) begin failures++; $display("FAIL cue_plus_obj: got score=%0d fouls=%0d ev=%b expected 15/1/1", score, fouls, scoreEvent); end
      tick();
      checks++; if (evCount != 1 || {aHide, bHide} !== 2'b11) begin failures++; $display("FAIL cue_plus_obj_once: got events=%0d hide=%b expected 1/11", evCount, {aHide, bHide}); end
      lvl[0] = 1'b0; tick(); lvl[0] = 1'b1; tick(); tick();
      checks++; if (fouls !== 4'd1) begin failures++; $display("FAIL cue_wait_ignore_a: got fouls=%0d expected 1", fouls); end
      lvl[0] = 1'b0; lvl[1] = 1'b0;
   endtask

   // Continues from test_cue_with_object: cue ball waiting, B and C pocketed.
   task automatic test_over_in_cuewait();
      respawnCount = 0;
      repeat (10) frame();
      lvl[3] = 1'b1; tick(); tick();
      checks++; if (dHide !== 1'b1 || gameOver !== 1'b0) begin failures++; $display("FAIL d_in_wait: got hide=%b over=%b expected 1/0", dHide, gameOver); end
      tick();
      checks++; if (gameOver !== 1'b1) begin failures++; $display("FAIL over_in_wait: got %b expected 1", gameOver); end
      for (int i = 0; i < 70; i++) begin
         lvl[0] = ~lvl[0]; lvl[1] = ~lvl[1];
         frame();
      end
      checks++; if (respawnCount != 0 || aHide !== 1'b1) begin failures++; $display("FAIL over_freezes_cue: got respawns=%0d hide=%b expected 0/1", respawnCount, aHide); end
      checks++; if (fouls !== 4'd1 || score !== 8'd25) begin failures++; $display("FAIL over_ignores: got fouls=%0d score=%0d expected 1/25", fouls, score); end
      lvl = '0;
   endtask

   task automatic test_saturation_and_restart();
      lvl = '0; restart();
      lvl[1] = 1'b1; lvl[2] = 1'b1; lvl[3] = 1'b1; tick(); tick();
      checks++; if (scoreS !== 4'd15 || scoreEventS !== 1'b1 || score !== 8'd30) begin failures++; $display("FAIL saturate: got scoreS=%0d evS=%b score=%0d expected 15/1/30", scoreS, scoreEventS, score); end
      lvl = '0; restart();
      lvl[0] = 1'b1; tick();
      newGame = 1'b1; tick(); newGame = 1'b0;
      checks++; if ({aHide, bHide, cHide, dHide, cueRespawn, scoreEvent, gameOver} !== 7'b0) begin failures++; $display("FAIL newgame_flags: got %b expected 0000000", {aHide, bHide, cHide, dHide, cueRespawn, scoreEvent, gameOver}); end
      checks++; if (fouls !== 4'd0 || score !== 8'd0 || scoreS !== 4'd0) begin failures++; $display("FAIL newgame_counts: got fouls=%0d score=%0d scoreS=%0d expected 0/0/0", fouls, score, scoreS); end
      tick(); tick();
      checks++; if (fouls !== 4'd1 || aHide !== 1'b1) begin failures++; $display("FAIL overlap_at_restart: got fouls=%0d hide=%b expected 1/1", fouls, aHide); end
      lvl = '0;
   endtask

   task automatic test_reset_abort();
      lvl = '0; restart();
      lvl[0] = 1'b1; tick(); tick(); lvl[0] = 1'b0;
      repeat (5) frame();
      #2 reset = 1'b1;
      #1;
      checks++; if (aHide !== 1'b0 || fouls !== 4'd0) begin failures++; $display("FAIL async_reset: got hide=%b fouls=%0d expected 0/0", aHide, fouls); end
      tick(); reset = 1'b0;
      respawnCount = 0;
      repeat (RESPAWN_FRAMES + 10) frame();
      checks++; if (respawnCount != 0 || aHide !== 1'b0) begin failures++; $display("FAIL reset_abort: got respawns=%0d hide=%b expected 0/0", respawnCount, aHide); end
   endtask

   task automatic test_random();
      lvl = '0; restart();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 7) == 0) lvl[b] = ~lvl[b];
         startOfFrame = 1'($urandom_range(0, 1));
         newGame = ($urandom_range(0, 149) == 0);
         tick();
         checks++; if ({dHide, cHide, bHide, aHide} !== 4'({mHide[3] != 0, mHide[2] != 0, mHide[1] != 0, mHide[0] != 0})) begin failures++; $display("FAIL rnd_hide cyc=%0d: got %b expected %b", cyc, {dHide, cHide, bHide, aHide}, {mHide[3] != 0, mHide[2] != 0, mHide[1] != 0, mHide[0] != 0}); end
         checks++; if (cueRespawn !== mResp) begin failures++; $display("FAIL rnd_respawn cyc=%0d: got %b expected %b", cyc, cueRespawn, mResp); end
         checks++; if (scoreEvent !== mEv) begin failures++; $display("FAIL rnd_score_event cyc=%0d: got %b expected %b", cyc, scoreEvent, mEv); end
         checks++; if (score !== 8'(mScore)) begin failures++; $display("FAIL rnd_score cyc=%0d: got %0d expected %0d", cyc, score, mScore); end
         checks++; if (fouls !== 4'(mFouls)) begin failures++; $display("FAIL rnd_fouls cyc=%0d: got %0d expected %0d", cyc, fouls, mFouls); end
         checks++; if (gameOver !== (mMode == M_OVER)) begin failures++; $display("FAIL rnd_game_over cyc=%0d: got %b expected %b", cyc, gameOver, mMode == M_OVER); end
         checks++; if (scoreS !== 4'(mScoreSat) || scoreEventS !== mEvSat) begin failures++; $display("FAIL rnd_sat cyc=%0d: got %0d/%b expected %0d/%b", cyc, scoreS, scoreEventS, mScoreSat, mEvSat); end
      end
      newGame = 1'b0; startOfFrame = 1'b0; lvl = '0;
   endtask

   initial begin
      modelClear();
      test_reset();
      test_hold_single();
      test_pair_then_over();
      test_cue_foul();
      test_cue_with_object();
      test_over_in_cuewait();
      test_saturation_and_restart();
      test_reset_abort();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
